// File: rtl/and_chain_seq_pkg.sv
// and_chain_seq_pkg
// Shared definitions for the time-shared AND chain controller:
//   state_t  - controller FSM encoding (IDLE, S1, S2, S3, DONE)
//   LAT_FULL - acceptance-to-out_valid latency when all three AND steps run
//   LAT_MIN  - shortest latency, when the chain short-circuits on a zero
//              product after S1 (only with AND_SEQ_EARLY_EXIT_EN)
package and_chain_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        S1,
        S2,
        S3,
        DONE
    } state_t;

    localparam int LAT_FULL = 4;
    localparam int LAT_MIN  = 2;

endpackage

// File: rtl/and_chain_seq_and2.sv
// and2_unit
// The single W-bit two-input AND that the controller time-shares across the
// three cascade steps. Purely combinational.
// Ports:
//   x_i, y_i : W-bit operands, chosen by the controller's operand mux
//   z_o      : W-bit bitwise AND of x_i and y_i
module and2_unit #(
    parameter int unsigned W = 1
) (
    input  logic [W-1:0] x_i,
    input  logic [W-1:0] y_i,
    output logic [W-1:0] z_o
);

    assign z_o = x_i & y_i;

endmodule

// File: rtl/and_chain_seq.sv
// and_chain_seq
// Multi-cycle controller computing e = a&b, f = e&c, g = f&d using one shared
// AND unit. Operands are accepted on a valid/ready port in IDLE, the three
// products are built in S1..S3, and held on a valid/ready output port in DONE.
// Ports:
//   clk, rst             : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready only in IDLE, not in reset)
//   a, b, c, d           : W-bit operands, captured only at acceptance
//   out_valid / out_ready: result handshake (out_valid only in DONE)
//   e, f, g              : W-bit cascaded products, registered, held until the
//                          next operation overwrites them
//   busy                 : high whenever the FSM is not in IDLE
// Build option:
//   AND_SEQ_EARLY_EXIT_EN - when defined, a zero product after S1 or S2 zeroes
//   the remaining results and jumps straight to DONE (latency 2 or 3).
module and_chain_seq
    import and_chain_seq_pkg::*;
#(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] e,
    output logic [W-1:0] f,
    output logic [W-1:0] g,
    output logic         busy
);

    state_t       state_q, state_d;
    logic [W-1:0] a_q, b_q, c_q, d_q;
    logic [W-1:0] a_d, b_d, c_d, d_d;
    logic [W-1:0] e_q, f_q, g_q;
    logic [W-1:0] e_d, f_d, g_d;
    logic [W-1:0] and_x, and_y, and_z;
    logic         accept;

    and2_unit #(
        .W(W)
    ) u_and2 (
        .x_i(and_x),
        .y_i(and_y),
        .z_o(and_z)
    );

    // Acceptance only depends on registered state plus in_valid; it feeds
    // state/operand registers, never an output.
    assign accept = in_valid && (state_q == IDLE);

    // ---------------- state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = S1;
`ifdef AND_SEQ_EARLY_EXIT_EN
            S1:   state_d = (and_z == '0) ? DONE : S2;
            S2:   state_d = (and_z == '0) ? DONE : S3;
`else
            S1:   state_d = S2;
            S2:   state_d = S3;
`endif
            S3:   state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- output / operand-select decode ----------------
    always_comb begin
        and_x = '0;
        and_y = '0;
        case (state_q)
            S1: begin
                and_x = a_q;
                and_y = b_q;
            end
            S2: begin
                and_x = e_q;
                and_y = c_q;
            end
            S3: begin
                and_x = f_q;
                and_y = d_q;
            end
            default: begin
                and_x = '0;
                and_y = '0;
            end
        endcase
    end

    // in_ready is forced low while rst is held: async reset parks the FSM in
    // IDLE, which would otherwise advertise readiness during reset.
    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign e         = e_q;
    assign f         = f_q;
    assign g         = g_q;

    // ---------------- datapath next values ----------------
    always_comb begin
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
        d_d = d_q;
        e_d = e_q;
        f_d = f_q;
        g_d = g_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d = a;
                    b_d = b;
                    c_d = c;
                    d_d = d;
                end
            end
            S1: begin
                e_d = and_z;
`ifdef AND_SEQ_EARLY_EXIT_EN
                // Downstream products of a zero are zero; clear stale results.
                if (and_z == '0) begin
                    f_d = '0;
                    g_d = '0;
                end
`endif
            end
            S2: begin
                f_d = and_z;
`ifdef AND_SEQ_EARLY_EXIT_EN
                if (and_z == '0) begin
                    g_d = '0;
                end
`endif
            end
            S3: g_d = and_z;
            default: begin
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            d_q <= '0;
            e_q <= '0;
            f_q <= '0;
            g_q <= '0;
        end else begin
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            d_q <= d_d;
            e_q <= e_d;
            f_q <= f_d;
            g_q <= g_d;
        end
    end

endmodule

// File: tb/tb_and_chain_seq.sv
// tb_and_chain_seq
// Directed bench for and_chain_seq at W=4: table-driven single operations
// plus hand-written sequences for backpressure, mid-operation reset and
// back-to-back streaming.
module tb_and_chain_seq;
    import and_chain_seq_pkg::*;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b, c, d;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] e, f, g;
    logic         busy;

    int total = 0;
    int bad   = 0;

    and_chain_seq #(
        .W(W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .e        (e),
        .f        (f),
        .g        (g),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a, b, c, d;
        logic [3:0] e, f, g;
        int         lat_full;
        int         lat_early;
    } vec_t;

    vec_t vecs[5];
    vec_t bb[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int exp_lat(input vec_t v);
`ifdef AND_SEQ_EARLY_EXIT_EN
        return v.lat_early;
`else
        return v.lat_full;
`endif
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 20) begin
            step();
            guard++;
        end
        chk({tag, " in_ready_before"}, in_ready, 1);
        a = v.a; b = v.b; c = v.c; d = v.d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk({tag, " busy"}, busy, 1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, lat, exp_lat(v));
        chk({tag, " e"}, e, v.e);
        chk({tag, " f"}, f, v.f);
        chk({tag, " g"}, g, v.g);
        chk({tag, " in_ready_done"}, in_ready, 0);
        step();
        chk({tag, " out_valid_after"}, out_valid, 0);
        chk({tag, " in_ready_after"}, in_ready, 1);
        chk({tag, " busy_after"}, busy, 0);
    endtask

    initial begin
        int n;
        int na, nr, cyc;
        int acc_t[3];
        logic hs_in, hs_out;

        vecs[0] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h7, 4'h3, 4'h1, LAT_FULL, LAT_FULL};
        vecs[1] = '{4'hF, 4'h0, 4'hF, 4'hF, 4'h0, 4'h0, 4'h0, LAT_FULL, LAT_MIN};
        vecs[2] = '{4'hA, 4'hE, 4'h6, 4'h7, 4'hA, 4'h2, 4'h2, LAT_FULL, LAT_FULL};
        vecs[3] = '{4'hF, 4'hC, 4'h3, 4'hF, 4'hC, 4'h0, 4'h0, LAT_FULL, 3};
        vecs[4] = '{4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, 4'h9, LAT_FULL, LAT_FULL};

        bb[0] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h7, 4'h3, 4'h1, LAT_FULL, LAT_FULL};
        bb[1] = '{4'hA, 4'hE, 4'h6, 4'h7, 4'hA, 4'h2, 4'h2, LAT_FULL, LAT_FULL};
        bb[2] = '{4'h5, 4'h5, 4'h5, 4'h4, 4'h5, 4'h5, 4'h4, LAT_FULL, LAT_FULL};

        // Reset state
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; c = '0; d = '0;
        #1;
        chk("rst in_ready", in_ready, 0);
        chk("rst out_valid", out_valid, 0);
        chk("rst busy", busy, 0);
        chk("rst e", e, 0);
        chk("rst f", f, 0);
        chk("rst g", g, 0);
        step();
        step();
        rst = 1'b0;
        #1;
        chk("post_rst in_ready", in_ready, 1);
        chk("post_rst out_valid", out_valid, 0);

        // Table-driven single operations (vecs[1] follows a nonzero g,
        // so a stale result would show up there)
        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: results held, inputs ignored, no accept in DONE
        out_ready = 1'b0;
        a = 4'hF; b = 4'h7; c = 4'h3; d = 4'h1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("bp out_valid_first", out_valid, 1);
        for (int i = 0; i < 10; i++) begin
            a = i[3:0]; b = ~i[3:0]; c = 4'h0; d = 4'hF;
            in_valid = 1'b1;
            step();
            chk("bp out_valid", out_valid, 1);
            chk("bp e", e, 4'h7);
            chk("bp f", f, 4'h3);
            chk("bp g", g, 4'h1);
            chk("bp in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp in_ready_after", in_ready, 1);
        chk("bp out_valid_after", out_valid, 0);
        chk("bp e_held", e, 4'h7);
        chk("bp f_held", f, 4'h3);
        chk("bp g_held", g, 4'h1);

        // Reset asserted during S2
        a = 4'hF; b = 4'h7; c = 4'h3; d = 4'h1;
        in_valid = 1'b1;
        step();           // accepted, now S1
        in_valid = 1'b0;
        step();           // now S2, e already written
        chk("mid busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid rst e", e, 0);
        chk("mid rst f", f, 0);
        chk("mid rst g", g, 0);
        chk("mid rst busy", busy, 0);
        chk("mid rst out_valid", out_valid, 0);
        chk("mid rst in_ready", in_ready, 0);
        step();
        chk("mid rst hold out_valid", out_valid, 0);
        chk("mid rst hold in_ready", in_ready, 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("aborted out_valid", out_valid, 0);
        end
        run_op('{4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, 4'h1, LAT_FULL, LAT_FULL}, "after_rst");

        // Back-to-back with in_valid held high
        out_ready = 1'b1;
        na = 0; nr = 0; cyc = 0;
        while ((na < 3 || nr < 3) && cyc < 60) begin
            if (na < 3) begin
                a = bb[na].a; b = bb[na].b; c = bb[na].c; d = bb[na].d;
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (hs_out && nr < 3) begin
                chk($sformatf("b2b%0d e", nr), e, bb[nr].e);
                chk($sformatf("b2b%0d f", nr), f, bb[nr].f);
                chk($sformatf("b2b%0d g", nr), g, bb[nr].g);
                nr++;
            end
            step();
            cyc++;
            if (hs_in) begin
                acc_t[na] = cyc;
                na++;
            end
        end
        in_valid = 1'b0;
        chk("b2b accepts", na, 3);
        chk("b2b results", nr, 3);
        if (na == 3) begin
            chk("b2b spacing01", acc_t[1] - acc_t[0], 5);
            chk("b2b spacing12", acc_t[2] - acc_t[1], 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
